decode_queue_ctrl: RTL and testbench



---
 rtl/decode_queue_ctrl_if.sv | 23 ++
 rtl/decode_queue_ctrl.sv | 104 ++++++++++
 tb/tb_decode_queue_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_ctrl_if.sv
// rtl/decode_queue_ctrl_if.sv - fetch-in / dispatch-out handshake bundle between IF and ID
interface decode_queue_ctrl_if #(
    parameter int PKT_W = 137
);
    logic [1:0]       in_valid;
    logic [PKT_W-1:0] in_pkt0;
    logic [PKT_W-1:0] in_pkt1;
    logic             in_ready;
    logic [1:0]       out_valid;
    logic [PKT_W-1:0] out_pkt0;
    logic [PKT_W-1:0] out_pkt1;
    logic [1:0]       out_accept;

    modport master (
        output in_valid, in_pkt0, in_pkt1, out_accept,
        input  in_ready, out_valid, out_pkt0, out_pkt1
    );

    modport slave (
        input  in_valid, in_pkt0, in_pkt1, out_accept,
        output in_ready, out_valid, out_pkt0, out_pkt1
    );
endinterface

// File: rtl/decode_queue_ctrl.sv
// rtl/decode_queue_ctrl.sv - IF-to-ID circular instruction buffer with dual-slot in-order dispatch
module decode_queue_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    decode_queue_ctrl_if.slave q
);
    localparam int PKT_W       = 137;
    localparam int NEMPTY_BIT  = 136;
    localparam int UNKNOWN_BIT = 135;
    localparam int EXC_HI      = 102;
    localparam int EXC_LO      = 96;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic [PTR_W-1:0] rd_ptr_p1;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PKT_W-1:0] head0;
    logic [PKT_W-1:0] head1;
    logic [PKT_W-1:0] wr_data0;
    logic             ready;
    logic             do_enq;
    logic             slot_v0;
    logic             slot_v1;
    logic             real0;
    logic             real1;
    logic             wr_en0;
    logic             wr_en1;
    logic [1:0]       enq_n;
    logic [1:0]       deq_n;
    logic [1:0]       vld;
    logic [1:0]       take;

    // Unknown opcodes and any raised exception code must reach decoder 0 by themselves
    function automatic logic is_special(input logic [PKT_W-1:0] p);
        return p[UNKNOWN_BIT] | (p[EXC_HI:EXC_LO] != 7'd0);
    endfunction

    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
    assign wr_ptr_p1 = wr_ptr + PTR_W'(1);

    // Registered count only: a same-cycle dequeue earns no credit
    assign ready = (DEPTH_C - count) >= TWO_C;

    // in_valid=10 collapses to no valid slot
    assign slot_v0 = q.in_valid[0];
    assign slot_v1 = q.in_valid[0] & q.in_valid[1];
    assign real0   = slot_v0 & q.in_pkt0[NEMPTY_BIT];
    assign real1   = slot_v1 & q.in_pkt1[NEMPTY_BIT];
    assign do_enq  = rstn & ~flush & ready;

    // A lone younger packet is compacted down into the wr_ptr slot
    assign wr_data0 = real0 ? q.in_pkt0 : q.in_pkt1;
    assign wr_en0   = do_enq & (real0 | real1);
    assign wr_en1   = do_enq & real0 & real1;
    assign enq_n    = do_enq ? {real0 & real1, real0 ^ real1} : 2'd0;

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr_p1];

    always_comb begin
        vld    = 2'b00;
        vld[0] = (count != '0);
        vld[1] = (count >= TWO_C) & ~is_special(head0) & ~is_special(head1);
    end

    assign take  = q.out_accept & vld;
    assign deq_n = {take[0] & take[1], take[0] ^ take[1]};

    assign q.in_ready  = ready;
    assign q.out_valid = vld;
    assign q.out_pkt0  = vld[0] ? head0 : '0;
    assign q.out_pkt1  = vld[1] ? head1 : '0;

    always_ff @(posedge clk) begin
        if (wr_en0) begin
            mem[wr_ptr] <= wr_data0;
        end
        if (wr_en1) begin
            mem[wr_ptr_p1] <= q.in_pkt1;
        end
    end

    // Reset and flush share the same clear; any same-cycle traffic is dropped
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(deq_n);
            wr_ptr <= wr_ptr + PTR_W'(enq_n);
            count  <= count + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
        end
    end
endmodule

// File: tb/tb_decode_queue_ctrl.sv
// tb/tb_decode_queue_ctrl.sv - directed and random checks of decode_queue_ctrl against a queue model
module tb_decode_queue_ctrl;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rstn;
    logic flush;

    decode_queue_ctrl_if dif ();

    decode_queue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .q     (dif)
    );

    always #5 clk = ~clk;

    logic [136:0] mq[$];
    int           nchk = 0;
    int           nerr = 0;
    logic         last_ir;
    logic [31:0]  pcn;

    function automatic logic spec(input logic [136:0] p);
        return p[135] || (p[102:96] != 7'd0);
    endfunction

    function automatic logic [136:0] mk(input bit ne, input bit unk, input logic [6:0] exc,
                                        input logic [31:0] pc);
        logic [31:0] badv;
        logic [31:0] inst;
        badv = $urandom;
        inst = $urandom;
        return {ne, unk, badv, exc, pc + 32'd4, pc, inst};
    endfunction

    task automatic chk(input string tag, input logic [136:0] obs, input logic [136:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the dispatch view with the model, then advance both across one edge
    task automatic tick();
        logic [1:0]   ev;
        logic         ir;
        logic [136:0] e0;
        logic [136:0] e1;
        int           n;
        ev = 2'b00;
        e0 = '0;
        e1 = '0;
        if (mq.size() >= 1) ev[0] = 1'b1;
        if (mq.size() >= 2) ev[1] = !spec(mq[0]) && !spec(mq[1]);
        if (ev[0]) e0 = mq[0];
        if (ev[1]) e1 = mq[1];
        ir = (DEPTH - mq.size()) >= 2;
        chk("out_valid", dif.out_valid, ev);
        chk("in_ready", dif.in_ready, ir);
        chk("out_pkt0", dif.out_pkt0, e0);
        chk("out_pkt1", dif.out_pkt1, e1);
        chk("count", dut.count, mq.size());
        @(posedge clk);
        if (!rstn || flush) begin
            mq.delete();
        end else begin
            n = int'(dif.out_accept[0] & ev[0]) + int'(dif.out_accept[1] & ev[1]);
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            if (ir) begin
                if (dif.in_valid[0] && dif.in_pkt0[136]) mq.push_back(dif.in_pkt0);
                if (dif.in_valid == 2'b11 && dif.in_pkt1[136]) mq.push_back(dif.in_pkt1);
            end
        end
        last_ir = ir && rstn && !flush;
        #1;
    endtask

    task automatic idle();
        dif.in_valid   = 2'b00;
        dif.out_accept = 2'b00;
    endtask

    task automatic drive_pair(input logic [31:0] pc);
        dif.in_valid = 2'b11;
        dif.in_pkt0  = mk(1, 0, 7'd0, pc);
        dif.in_pkt1  = mk(1, 0, 7'd0, pc + 32'd4);
    endtask

    initial begin
        rstn           = 1'b0;
        flush          = 1'b0;
        dif.in_valid   = 2'b00;
        dif.in_pkt0    = '0;
        dif.in_pkt1    = '0;
        dif.out_accept = 2'b00;
        last_ir        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", dif.out_valid, 2'b00);
        chk("rst_in_ready", dif.in_ready, 1'b1);
        chk("rst_out_pkt0", dif.out_pkt0, '0);
        chk("rst_rd_ptr", dut.rd_ptr, 3'd0);
        rstn = 1'b1;

        // Reset/fill
        dif.in_valid = 2'b11;
        dif.in_pkt0  = mk(1, 0, 7'd0, 32'h1c000000);
        dif.in_pkt1  = mk(1, 0, 7'd0, 32'h1c000004);
        tick();
        idle();
        chk("fill_valid", dif.out_valid, 2'b11);
        chk("fill_pc0", dif.out_pkt0[63:32], 32'h1c000000);
        chk("fill_pc1", dif.out_pkt1[63:32], 32'h1c000004);
        chk("fill_count", dut.count, 4'd2);
        tick();
        dif.out_accept = 2'b11;
        tick();
        idle();

        // Bubble compaction
        dif.in_valid = 2'b11;
        dif.in_pkt0  = mk(0, 0, 7'd0, 32'h1c00000c);
        dif.in_pkt1  = mk(1, 0, 7'd0, 32'h1c000010);
        tick();
        idle();
        chk("bub_valid", dif.out_valid, 2'b01);
        chk("bub_pc0", dif.out_pkt0[63:32], 32'h1c000010);
        chk("bub_pkt1", dif.out_pkt1, '0);
        dif.out_accept = 2'b01;
        tick();

        // Exception serialization, then unknown second packet
        dif.in_valid = 2'b11;
        dif.in_pkt0  = mk(1, 0, 7'h08, 32'h1c000020);
        dif.in_pkt1  = mk(1, 0, 7'd0, 32'h1c000024);
        dif.out_accept = 2'b00;
        tick();
        idle();
        chk("exc_valid_a", dif.out_valid, 2'b01);
        chk("exc_pc_a", dif.out_pkt0[63:32], 32'h1c000020);
        dif.out_accept = 2'b01;
        tick();
        chk("exc_valid_b", dif.out_valid, 2'b01);
        chk("exc_pc_b", dif.out_pkt0[63:32], 32'h1c000024);
        tick();
        idle();
        dif.in_valid = 2'b11;
        dif.in_pkt0  = mk(1, 0, 7'd0, 32'h1c000030);
        dif.in_pkt1  = mk(1, 1, 7'd0, 32'h1c000034);
        tick();
        idle();
        chk("unk_valid_a", dif.out_valid, 2'b01);
        dif.out_accept = 2'b01;
        tick();
        chk("unk_valid_b", dif.out_valid, 2'b01);
        chk("unk_pc_b", dif.out_pkt0[63:32], 32'h1c000034);
        tick();
        idle();

        // Full and pointer wrap
        pcn = 32'h1c001000;
        for (int i = 0; i < 3; i++) begin
            drive_pair(pcn);
            tick();
            pcn += 32'd8;
        end
        dif.in_valid = 2'b01;
        dif.in_pkt0  = mk(1, 0, 7'd0, pcn);
        tick();
        pcn += 32'd4;
        chk("full_count_a", dut.count, 4'd7);
        drive_pair(pcn);
        tick();
        tick();
        chk("full_ready", dif.in_ready, 1'b0);
        chk("full_count_b", dut.count, 4'd7);
        dif.out_accept = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (last_ir) begin
                pcn += 32'd8;
                drive_pair(pcn);
            end
        end
        dif.in_valid = 2'b00;
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) tick();
        chk("drain_valid", dif.out_valid, 2'b00);
        idle();

        // Flush with traffic on both sides
        drive_pair(32'h1c002000);
        tick();
        drive_pair(32'h1c002008);
        tick();
        dif.in_valid = 2'b01;
        dif.in_pkt0  = mk(1, 0, 7'd0, 32'h1c002010);
        tick();
        chk("pre_flush_count", dut.count, 4'd5);
        flush = 1'b1;
        drive_pair(32'h1c00f000);
        dif.out_accept = 2'b11;
        tick();
        flush = 1'b0;
        idle();
        chk("flush_count", dut.count, 4'd0);
        chk("flush_valid", dif.out_valid, 2'b00);
        chk("flush_ready", dif.in_ready, 1'b1);
        tick();
        tick();

        // Reset during flush with a partly full queue
        for (int i = 0; i < 3; i++) begin
            drive_pair(32'h1c003000 + 32'(i * 8));
            tick();
        end
        chk("pre_rst_count", dut.count, 4'd6);
        rstn  = 1'b0;
        flush = 1'b1;
        tick();
        rstn  = 1'b1;
        flush = 1'b0;
        idle();
        chk("mid_rst_rd_ptr", dut.rd_ptr, 3'd0);
        chk("mid_rst_wr_ptr", dut.wr_ptr, 3'd0);
        chk("mid_rst_valid", dif.out_valid, 2'b00);
        chk("mid_rst_pkt0", dif.out_pkt0, '0);
        chk("mid_rst_pkt1", dif.out_pkt1, '0);

        // Random traffic
        pcn = 32'h1c010000;
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(3))
                0:       dif.in_valid = 2'b00;
                1:       dif.in_valid = 2'b01;
                2:       dif.in_valid = 2'b11;
                default: dif.in_valid = 2'b10;
            endcase
            dif.in_pkt0 = mk($urandom_range(3) != 0, $urandom_range(7) == 0,
                             ($urandom_range(7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0, pcn);
            dif.in_pkt1 = mk($urandom_range(3) != 0, $urandom_range(7) == 0,
                             ($urandom_range(7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0, pcn + 32'd4);
            pcn += 32'd8;
            case ($urandom_range(2))
                0:       dif.out_accept = 2'b00;
                1:       dif.out_accept = 2'b01;
                default: dif.out_accept = 2'b11;
            endcase
            flush = ($urandom_range(31) == 0);
            tick();
        end
        flush = 1'b0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
